// File: rtl/io_pulse_pkg.sv
// Shared state encoding and sizing helpers for the io pulse generator.
package io_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter used as the pending-event queue depth.
module sat_updown_counter #(
  parameter int unsigned p_MAX = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(p_MAX+1)-1:0]   count,
  output logic [$clog2(p_MAX+1)-1:0]   count_next_c,
  output logic                         overflow
);

  localparam int unsigned W = $clog2(p_MAX + 1);

  logic [W-1:0] count_q, count_d;
  logic         overflow_q, overflow_d;

  // Next count: simultaneous inc+dec is a net no-op and never overflows.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (inc && !dec) begin
      if (count_q == W'(p_MAX)) overflow_d = 1'b1;
      else                      count_d    = count_q + W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - W'(1);
    end
  end

  // Count and one-cycle overflow flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count        = count_q;
  assign count_next_c = count_d;
  assign overflow     = overflow_q;

endmodule

// File: rtl/pulse_generator.sv
// Turns one-cycle strobes into fixed-width pulses with a minimum gap,
// queueing strobes that arrive while a pulse or gap is in progress.
module pulse_generator
  import io_pulse_pkg::*;
#(
  parameter int unsigned p_HIGH_CYCLES = 3,
  parameter int unsigned p_LOW_CYCLES  = 2,
  parameter int unsigned p_MAX_PENDING = 2,
  parameter bit          p_ACTIVE_HIGH = 1'b1
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_strobe,
  output logic                               o_pulse,
  output logic                               o_busy,
  output logic [$clog2(p_MAX_PENDING+1)-1:0] o_pending,
  output logic                               o_overflow
);

  localparam int unsigned PW  = $clog2(p_MAX_PENDING + 1);
  localparam int unsigned CW  = width_for(max_of(p_HIGH_CYCLES, p_LOW_CYCLES));
  localparam logic        ACT = p_ACTIVE_HIGH ? 1'b1 : 1'b0;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          inc_c, dec_c;
  logic [PW-1:0] pend, pend_next_c;

  // Pending-event queue depth.
  sat_updown_counter #(
    .p_MAX (p_MAX_PENDING)
  ) u_pending (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .inc          (inc_c),
    .dec          (dec_c),
    .count        (pend),
    .count_next_c (pend_next_c),
    .overflow     (o_overflow)
  );

  // Next state, cycle counter and queue control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_c   = 1'b0;
    dec_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_strobe) begin
          state_d = HIGH;
          cnt_d   = CW'(p_HIGH_CYCLES - 1);
        end
      end
      HIGH: begin
        inc_c = i_strobe;
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = CW'(p_LOW_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          inc_c = i_strobe;
          cnt_d = cnt_q - CW'(1);
        end else if (pend != '0) begin
          // Dequeue one event; a simultaneous strobe takes its slot.
          dec_c   = 1'b1;
          inc_c   = i_strobe;
          state_d = HIGH;
          cnt_d   = CW'(p_HIGH_CYCLES - 1);
        end else if (i_strobe) begin
          state_d = HIGH;
          cnt_d   = CW'(p_HIGH_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered output levels follow the next state so nothing lags.
  always_comb begin
    pulse_d = (state_d == HIGH) ? ACT : ~ACT;
    busy_d  = (state_d != IDLE) || (pend_next_c != '0);
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= ~ACT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_busy    = busy_q;
  assign o_pending = pend;

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench: active-high and active-low instances share stimulus
// and are compared each cycle against a timeline model of pulse windows.
module tb_pulse_generator;

  localparam int H    = 3;
  localparam int L    = 2;
  localparam int MAXP = 2;

  logic       clk;
  logic       rst_n;
  logic       strobe;
  logic       pulse_a, busy_a, ovf_a;
  logic [1:0] pend_a;
  logic       pulse_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int checks   = 0;
  int failures = 0;

  // Model: start cycle of the current pulse window, queued events, cycle index.
  bit m_active;
  int m_start;
  int m_pend;
  bit m_ovf;
  int m_now;

  int hi_cnt, lo_cnt, ovf_cnt, max_pend;

  pulse_generator #(
    .p_HIGH_CYCLES (H), .p_LOW_CYCLES (L), .p_MAX_PENDING (MAXP), .p_ACTIVE_HIGH (1'b1)
  ) dut_a (
    .i_clk (clk), .i_rst_n (rst_n), .i_strobe (strobe),
    .o_pulse (pulse_a), .o_busy (busy_a), .o_pending (pend_a), .o_overflow (ovf_a)
  );

  pulse_generator #(
    .p_HIGH_CYCLES (H), .p_LOW_CYCLES (L), .p_MAX_PENDING (MAXP), .p_ACTIVE_HIGH (1'b0)
  ) dut_b (
    .i_clk (clk), .i_rst_n (rst_n), .i_strobe (strobe),
    .o_pulse (pulse_b), .o_busy (busy_b), .o_pending (pend_b), .o_overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0;
    m_start  = 0;
    m_pend   = 0;
    m_ovf    = 1'b0;
    m_now    = 0;
  endtask

  // Advance the model by one clock edge with strobe value st sampled.
  task automatic m_step(input bit st);
    bit ovf_n;
    ovf_n = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1;
        m_start  = m_now + 1;
      end
    end else if (m_now == m_start + H + L - 1) begin
      if (m_pend > 0 || st) begin
        m_start = m_now + 1;
        if (m_pend > 0 && !st) m_pend--;
      end else begin
        m_active = 1'b0;
      end
    end else if (st) begin
      if (m_pend < MAXP) m_pend++;
      else               ovf_n = 1'b1;
    end
    m_ovf = ovf_n;
    m_now++;
  endtask

  task automatic check_all();
    bit on;
    on = m_active && (m_now < m_start + H);
    chk("pulse_a",   32'(pulse_a), 32'(on));
    chk("pulse_b",   32'(pulse_b), 32'(!on));
    chk("busy_a",    32'(busy_a),  32'(m_active || m_pend > 0));
    chk("busy_b",    32'(busy_b),  32'(m_active || m_pend > 0));
    chk("pending_a", 32'(pend_a),  32'(m_pend));
    chk("pending_b", 32'(pend_b),  32'(m_pend));
    chk("overflow_a", 32'(ovf_a),  32'(m_ovf));
    chk("overflow_b", 32'(ovf_b),  32'(m_ovf));
  endtask

  // One clock cycle: drive strobe, take the edge, update model, sample.
  task automatic cyc(input bit st);
    strobe = st;
    @(posedge clk);
    m_step(st);
    #1;
    if (pulse_a === 1'b1) hi_cnt++;
    if (pulse_b === 1'b0) lo_cnt++;
    if (ovf_a === 1'b1) ovf_cnt++;
    if (int'(pend_a) > max_pend) max_pend = int'(pend_a);
    check_all();
    strobe = 1'b0;
  endtask

  task automatic clear_stats();
    hi_cnt = 0; lo_cnt = 0; ovf_cnt = 0; max_pend = 0;
  endtask

  // Apply a strobe pattern (bit e = strobe at edge e), then idle to drain.
  task automatic scenario(input logic [31:0] pat, input int n_edges, input int exp_pulses,
                          input int exp_ovf, input string tag);
    clear_stats();
    for (int e = 0; e < n_edges; e++) cyc(pat[e]);
    chk({tag, "_pulse_cycles_a"}, 32'(hi_cnt), 32'(exp_pulses * H));
    chk({tag, "_pulse_cycles_b"}, 32'(lo_cnt), 32'(exp_pulses * H));
    chk({tag, "_overflows"},      32'(ovf_cnt), 32'(exp_ovf));
    chk({tag, "_idle_at_end"},    32'(busy_a), 32'(0));
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk({tag, "_rst_pulse_a"}, 32'(pulse_a), 32'(0));
    chk({tag, "_rst_pulse_b"}, 32'(pulse_b), 32'(1));
    chk({tag, "_rst_pending"}, 32'(pend_a),  32'(0));
    chk({tag, "_rst_busy"},    32'(busy_a),  32'(0));
    chk({tag, "_rst_ovf"},     32'(ovf_a),   32'(0));
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] pat;
    int density;
    strobe = 1'b0;
    rst_n  = 1'b0;
    m_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pulse_a", 32'(pulse_a), 32'(0));
    chk("reset_pulse_b", 32'(pulse_b), 32'(1));
    chk("reset_busy",    32'(busy_a),  32'(0));
    chk("reset_pending", 32'(pend_a),  32'(0));
    chk("reset_ovf",     32'(ovf_a),   32'(0));
    rst_n = 1'b1;
    cyc(1'b0);
    m_reset();

    // Single strobe.
    pat = 32'h0000_0001; scenario(pat, 12, 1, 0, "single");
    // Strobes at edges 0..2: three pulses queued back to back.
    pat = 32'h0000_0007; scenario(pat, 20, 3, 0, "three");
    chk("three_max_pending", 32'(max_pend), 32'(2));
    // Strobes at edges 0..3: fourth is dropped.
    pat = 32'h0000_000F; scenario(pat, 20, 3, 1, "overflow");
    chk("overflow_max_pending", 32'(max_pend), 32'(2));
    // Strobe on the gap-terminal cycle with nothing queued.
    pat = 32'h0000_0021; scenario(pat, 16, 2, 0, "terminal_direct");
    // Strobe on the gap-terminal cycle with one queued.
    pat = 32'h0000_0023; scenario(pat, 20, 3, 0, "terminal_queued");

    // Reset in the middle of a pulse with events queued.
    cyc(1'b1);
    cyc(1'b1);
    async_reset_check("midpulse");
    clear_stats();
    for (int i = 0; i < 8; i++) cyc(1'b0);
    chk("post_reset_no_pulse", 32'(hi_cnt), 32'(0));

    // Randomized traffic with varying density and occasional resets.
    density = 30;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) density = int'($urandom_range(5, 90));
      if ($urandom_range(0, 199) == 0) async_reset_check("rand");
      else cyc($urandom_range(0, 99) < density);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0);
    chk("final_idle", 32'(busy_a), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Inverse of the io-library edge detector: turns single-cycle event strobes into level pulses of fixed width with a guaranteed minimum gap between them.
- Strobes that arrive while a pulse or gap is in progress are counted and replayed in order, up to a bounded depth.
- Sits in lib/io. Drives LEDs, external trigger pins and slow peripherals from one-cycle edge-detector outputs.

Parameters:
- p_HIGH_CYCLES, 3: cycles the output is held active per event; must be ≥1.
- p_LOW_CYCLES, 2: minimum inactive cycles after each pulse; must be ≥1.
- p_MAX_PENDING, 2: maximum queued events beyond the one in progress; must be ≥1.
- p_ACTIVE_HIGH, 1: 1 means the pulse is driven high; 0 means the pulse is driven low.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_strobe  in  1  event request; each cycle it is high counts as one event.
- o_pulse  out  1  shaped output pulse, registered.
- o_busy  out  1  high while a pulse or gap is in progress or events are queued; registered.
- o_pending  out  PW  queued event count, where PW = $clog2(p_MAX_PENDING+1).
- o_overflow  out  1  one-cycle flag: an event was dropped because the queue was full.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, cycle counter = 0, o_pending = 0.
  - o_pulse = inactive level (0 if p_ACTIVE_HIGH, else 1).
  - o_busy = 0, o_overflow = 0.
  - Takes effect immediately, including mid-pulse; queued events are discarded.
- States: IDLE, HIGH, LOW. Cycle counter width = $clog2(max(p_HIGH_CYCLES, p_LOW_CYCLES)+1).
- IDLE:
  - i_strobe=1 → HIGH, counter loaded with p_HIGH_CYCLES-1.
  - o_pulse goes active on the same edge, so latency is 1 cycle from the strobe sample.
- HIGH:
  - o_pulse active. Counter decrements each cycle.
  - When counter==0 → LOW, counter loaded with p_LOW_CYCLES-1, o_pulse goes inactive.
  - Active time is exactly p_HIGH_CYCLES cycles.
- LOW:
  - o_pulse inactive. Counter decrements each cycle.
  - When counter==0: if o_pending>0 or i_strobe=1 → HIGH (reload), else → IDLE.
  - Inactive time is at least p_LOW_CYCLES cycles, so consecutive pulse starts are p_HIGH_CYCLES+p_LOW_CYCLES apart.
- Queueing, in any state other than IDLE and other than the LOW-terminal cycle:
  - i_strobe=1 with o_pending<p_MAX_PENDING → o_pending+1.
  - i_strobe=1 with o_pending==p_MAX_PENDING → event dropped; o_overflow=1 for exactly the next cycle.
- LOW-terminal cycle with o_pending>0:
  - One event is dequeued to start the next pulse.
  - A simultaneous i_strobe is enqueued, so o_pending is unchanged (net 0).
  - A simultaneous strobe never overflows in this cycle.
- LOW-terminal cycle with o_pending==0 and i_strobe=1: the strobe starts the next pulse directly; o_pending stays 0.
- o_busy: registered, equals (next state ≠ IDLE) or (next o_pending ≠ 0). It tracks state exactly (no extra cycle of lag).
- No arithmetic wrap: o_pending saturates at p_MAX_PENDING and the counter never underflows.

Decomposition:
- Shared package io_pulse_pkg holds:
  - the state encoding constants IDLE=2'd0, HIGH=2'd1, LOW=2'd2;
  - a width helper for counter and pending sizing.
- Sub-module sat_updown_counter (parameter p_MAX; inputs inc, dec; output count; output overflow when inc at max without dec) implements the pending queue.
- The FSM and cycle counter stay in pulse_generator.

Test Plan (p_HIGH_CYCLES=3, p_LOW_CYCLES=2, p_MAX_PENDING=2, p_ACTIVE_HIGH=1 unless stated; cycle n = after clock edge n):
1. Single strobe sampled at edge 0 → o_pulse=1 cycles 1–3, 0 from cycle 4; o_busy=1 cycles 1–5, 0 at cycle 6; o_overflow never asserted.
2. Strobes at edges 0, 1, 2 → pulses start at cycles 1, 6, 11, each 3 cycles wide. o_pending = 1 at cycle 2, then 2 at cycle 3, then 1 at cycle 6, then 0 at cycle 11. o_busy falls at cycle 16.
3. Strobes at edges 0–3 → o_overflow=1 at cycle 4 only; exactly three pulses produced; o_pending never exceeds 2.
4. Strobes at edge 0 and at edge 5 (the LOW-terminal cycle, with o_pending=0) → second pulse starts cycle 6 with no gap extension; o_pending stays 0.
5. Same as 4, but with an extra strobe at edge 1 (pending=1 at edge 5) → second pulse at cycle 6; o_pending remains 1; third pulse at cycle 11.
6. Assert i_rst_n=0 mid-pulse (cycle 2 of scenario 2) → o_pulse=0, o_pending=0, o_busy=0 immediately without a clock edge; no pulses after release. Repeat scenario 1 with p_ACTIVE_HIGH=0 → o_pulse=1 at reset, 0 during cycles 1–3.
